// File: rtl/cbu_cascade_up_pkg.sv
// Shared counter-library definitions: width limit and terminal-count helper.
package cbu_cascade_up_pkg;

   localparam int unsigned MAX_WIDTH = 32;

   // Terminal count of a sequence: MODULUS-1, or all-ones when MODULUS is 0.
   function automatic logic [MAX_WIDTH-1:0] last_count(input int unsigned     width,
                                                       input longint unsigned modulus);
      longint unsigned full;
      if (modulus == 64'd0) begin
         full = (64'd1 << width) - 64'd1;
      end else begin
         full = modulus - 64'd1;
      end
      return full[MAX_WIDTH-1:0];
   endfunction

endpackage : cbu_cascade_up_pkg

// File: rtl/cbu_cascade_up.sv
// Cascadable up counter with programmable modulus, saturating load, combinational
// carry-out and a sticky rollover flag. Chain CAO into the next stage's CAI.
module cbu_cascade_up
   import cbu_cascade_up_pkg::*;
#(
   parameter int unsigned     WIDTH   = 4,
   parameter longint unsigned MODULUS = 0
) (
   input  logic             CLK,
   input  logic             CDN,
   input  logic             EN,
   input  logic             CAI,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             CAO,
   output logic             WRAP
);

   // Reject illegal parameter combinations at elaboration.
   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("cbu_cascade_up: WIDTH must be within 1..MAX_WIDTH");
   end
   if (MODULUS != 64'd0 && (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH))) begin : g_bad_mod
      $error("cbu_cascade_up: MODULUS must be 0 or within 2..2**WIDTH");
   end

   localparam logic [MAX_WIDTH-1:0] LastFull = last_count(WIDTH, MODULUS);
   localparam logic [WIDTH-1:0]     Last     = LastFull[WIDTH-1:0];

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic             at_last;

   assign at_last = (q_q == Last);

   // Next state: load beats count; otherwise hold.
   always_comb begin
      q_d    = q_q;
      wrap_d = wrap_q;
      if (LD) begin
         q_d    = (D > Last) ? Last : D;
         wrap_d = 1'b0;
      end else if (EN && CAI) begin
         // Full-range counters roll over naturally; shorter moduli wrap explicitly.
         q_d = q_q + 1'b1;
         if (MODULUS != 64'd0 && at_last) begin
            q_d = '0;
         end
         if (at_last) begin
            wrap_d = 1'b1;
         end
      end
   end

   // State register with synchronous active-low reset taking top priority.
   always_ff @(posedge CLK) begin
      if (!CDN) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   // Carry-out ripples combinationally so a chain advances in a single cycle.
   assign CAO  = CAI & EN & at_last;
   assign Q    = q_q;
   assign WRAP = wrap_q;

endmodule : cbu_cascade_up

// File: tb/tb_cbu_cascade_up.sv
// Self-checking bench for cbu_cascade_up: vector table, directed corner sequences,
// a two-stage decade cascade and randomized checks against a behavioural model.
module tb_cbu_cascade_up;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Stage A: WIDTH=4, MODULUS=0
   logic       a_cdn, a_en, a_cai, a_ld, a_cao, a_wrap;
   logic [3:0] a_d, a_q;
   cbu_cascade_up #(.WIDTH(4), .MODULUS(0)) u_a (
      .CLK(clk), .CDN(a_cdn), .EN(a_en), .CAI(a_cai), .LD(a_ld), .D(a_d),
      .Q(a_q), .CAO(a_cao), .WRAP(a_wrap)
   );

   // Stage B: WIDTH=4, MODULUS=10
   logic       b_cdn, b_en, b_cai, b_ld, b_cao, b_wrap;
   logic [3:0] b_d, b_q;
   cbu_cascade_up #(.WIDTH(4), .MODULUS(10)) u_b (
      .CLK(clk), .CDN(b_cdn), .EN(b_en), .CAI(b_cai), .LD(b_ld), .D(b_d),
      .Q(b_q), .CAO(b_cao), .WRAP(b_wrap)
   );

   // Toggle cell: WIDTH=1, MODULUS=0
   logic       t_cdn, t_en, t_cai, t_ld, t_cao, t_wrap;
   logic [0:0] t_d, t_q;
   cbu_cascade_up #(.WIDTH(1), .MODULUS(0)) u_t (
      .CLK(clk), .CDN(t_cdn), .EN(t_en), .CAI(t_cai), .LD(t_ld), .D(t_d),
      .Q(t_q), .CAO(t_cao), .WRAP(t_wrap)
   );

   // Two-stage decade cascade
   logic       c_cdn, c_en, c0_cao, c1_cao, c0_wrap, c1_wrap;
   logic [3:0] c0_q, c1_q;
   cbu_cascade_up #(.WIDTH(4), .MODULUS(10)) u_c0 (
      .CLK(clk), .CDN(c_cdn), .EN(c_en), .CAI(1'b1), .LD(1'b0), .D(4'd0),
      .Q(c0_q), .CAO(c0_cao), .WRAP(c0_wrap)
   );
   cbu_cascade_up #(.WIDTH(4), .MODULUS(10)) u_c1 (
      .CLK(clk), .CDN(c_cdn), .EN(c_en), .CAI(c0_cao), .LD(1'b0), .D(4'd0),
      .Q(c1_q), .CAO(c1_cao), .WRAP(c1_wrap)
   );

   typedef struct {
      logic       cdn, ld, en, cai;
      logic [3:0] d;
      logic [3:0] q;
      logic       wrap, cao;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic cdn, logic ld, logic en, logic cai, int d,
                               int q, logic wrap, logic cao);
      vec_t v;
      v.cdn = cdn; v.ld = ld; v.en = en; v.cai = cai; v.d = 4'(d);
      v.q = 4'(q); v.wrap = wrap; v.cao = cao;
      return v;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour written directly from the counting rules.
   function automatic void model_step(inout int m, inout int w, input bit cdn, input bit ld,
                                      input bit en, input bit cai, input int d, input int last);
      if (!cdn) begin
         m = 0; w = 0;
      end else if (ld) begin
         m = (d > last) ? last : d; w = 0;
      end else if (en && cai) begin
         if (m == last) begin
            m = 0; w = 1;
         end else begin
            m = m + 1;
         end
      end
   endfunction

   int ma, wa, mb, wb, mt, wt;

   initial begin
      a_cdn = 0; a_en = 0; a_cai = 0; a_ld = 0; a_d = '0;
      b_cdn = 0; b_en = 0; b_cai = 0; b_ld = 0; b_d = '0;
      t_cdn = 0; t_en = 0; t_cai = 0; t_ld = 0; t_d = '0;
      c_cdn = 0; c_en = 0;

      // Vector table for stage A
      vecs.push_back(mk(0, 1, 1, 1, 9, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 9, 0, 0, 0));
      for (int k = 1; k <= 17; k++)
         vecs.push_back(mk(1, 0, 1, 1, 0, k % 16, k >= 16, (k % 16) == 15));
      vecs.push_back(mk(0, 1, 1, 1, 5, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 5, 5, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 7, 7, 0, 0));
      for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 0, 1, 0, 0, 7, 0, 0));
      for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 0, 0, 1, 0, 7, 0, 0));
      vecs.push_back(mk(1, 0, 1, 1, 0, 8, 0, 0));

      @(negedge clk);
      foreach (vecs[i]) begin
         a_cdn = vecs[i].cdn; a_ld = vecs[i].ld; a_en = vecs[i].en;
         a_cai = vecs[i].cai; a_d = vecs[i].d;
         tick();
         check($sformatf("vec%0d q", i), a_q, vecs[i].q);
         check($sformatf("vec%0d wrap", i), a_wrap, vecs[i].wrap);
         check($sformatf("vec%0d cao", i), a_cao, vecs[i].cao);
      end

      // CAO ignores LD during the load cycle
      a_cdn = 1; a_ld = 1; a_en = 0; a_cai = 0; a_d = 4'd15;
      tick();
      check("ld15 q", a_q, 15);
      a_ld = 1; a_en = 1; a_cai = 1; a_d = 4'd3;
      #1;
      check("cao during load", a_cao, 1);
      tick();
      check("ld3 q", a_q, 3);
      check("ld3 cao", a_cao, 0);

      // Reset overrides unknown EN/CAI
      a_cdn = 0; a_ld = 0; a_en = 1'bx; a_cai = 1'bx;
      tick();
      check("x reset q", a_q, 0);
      check("x reset wrap", a_wrap, 0);

      // Decade sequence on stage B
      b_cdn = 0;
      tick();
      b_cdn = 1; b_en = 1; b_cai = 1;
      #1;
      check("dec start q", b_q, 0);
      check("dec start cao", b_cao, 0);
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("dec%0d q", k), b_q, k % 10);
         check($sformatf("dec%0d cao", k), b_cao, (k % 10) == 9);
      end
      check("dec wrap", b_wrap, 1);
      b_ld = 1; b_d = 4'd12;
      tick();
      check("sat q", b_q, 9);
      check("sat wrap", b_wrap, 0);
      check("sat cao", b_cao, 1);
      b_ld = 0;
      tick();
      check("post sat q", b_q, 0);
      check("post sat wrap", b_wrap, 1);

      // Two-stage cascade for 105 edges
      c_cdn = 0;
      tick();
      c_cdn = 1; c_en = 1;
      for (int k = 1; k <= 105; k++) begin
         tick();
         check($sformatf("casc%0d value", k), c1_q * 10 + c0_q, k % 100);
         check($sformatf("casc%0d wrap0", k), c0_wrap, k >= 10);
      end
      check("casc hi q", c1_q, 0);
      check("casc lo q", c0_q, 5);
      check("casc hi wrap", c1_wrap, 1);

      // Randomized checks against the model
      ma = 0; wa = 0; mb = 0; wb = 0; mt = 0; wt = 0;
      for (int i = 0; i < 400; i++) begin
         a_cdn = (i == 0) ? 1'b0 : ($urandom_range(0, 15) != 0);
         a_ld  = ($urandom_range(0, 7) == 0);
         a_en  = ($urandom_range(0, 3) != 0);
         a_cai = ($urandom_range(0, 3) != 0);
         a_d   = 4'($urandom_range(0, 15));
         b_cdn = (i == 0) ? 1'b0 : ($urandom_range(0, 15) != 0);
         b_ld  = ($urandom_range(0, 7) == 0);
         b_en  = ($urandom_range(0, 3) != 0);
         b_cai = ($urandom_range(0, 3) != 0);
         b_d   = 4'($urandom_range(0, 15));
         t_cdn = (i == 0) ? 1'b0 : ($urandom_range(0, 15) != 0);
         t_ld  = ($urandom_range(0, 7) == 0);
         t_en  = ($urandom_range(0, 3) != 0);
         t_cai = ($urandom_range(0, 3) != 0);
         t_d   = 1'($urandom_range(0, 1));
         model_step(ma, wa, a_cdn, a_ld, a_en, a_cai, int'(a_d), 15);
         model_step(mb, wb, b_cdn, b_ld, b_en, b_cai, int'(b_d), 9);
         model_step(mt, wt, t_cdn, t_ld, t_en, t_cai, int'(t_d), 1);
         tick();
         check($sformatf("rndA%0d q", i), a_q, ma);
         check($sformatf("rndA%0d wrap", i), a_wrap, wa);
         check($sformatf("rndA%0d cao", i), a_cao, a_en && a_cai && ma == 15);
         check($sformatf("rndB%0d q", i), b_q, mb);
         check($sformatf("rndB%0d wrap", i), b_wrap, wb);
         check($sformatf("rndB%0d cao", i), b_cao, b_en && b_cai && mb == 9);
         check($sformatf("rndT%0d q", i), t_q, mt);
         check($sformatf("rndT%0d wrap", i), t_wrap, wt);
         check($sformatf("rndT%0d cao", i), t_cao, t_en && t_cai && mt == 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_cbu_cascade_up
